// File: rtl/arb_client.sv
// rtl/arb_client.sv - requester-side arbiter client: request, burst transfer, grant-loss abort
// Optional grant-wait timeout: define ARB_CLIENT_TIMEOUT_EN (limit set by TIMEOUT, must be >= 1).
module arb_client #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_XFER  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   base_q;
    // One bit wider than len so the count can reach 2^LEN_W without wrapping.
    logic [LEN_W:0]      count_q;
    logic                req_q;
    logic                bus_valid_q;
    logic [DATA_W-1:0]   bus_data_q;
    logic                bus_last_q;
    logic                done_q;
    logic                err_q;

    logic [DATA_W-1:0]   beat_data_d;
    logic                last_beat_d;

`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0]   wait_q;
`else
    localparam int timeout_unused = TIMEOUT;
`endif

    // Payload of the beat about to be emitted; wraps silently modulo 2^DATA_W.
    assign beat_data_d = base_q + DATA_W'(count_q);
    assign last_beat_d = (count_q == {1'b0, len_q});

    // A grant still high from the previous burst blocks a new command.
    assign cmd_ready = (state_q == S_IDLE) && !gnt;
    assign busy      = (state_q != S_IDLE);

    assign req       = req_q;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign bus_last  = bus_last_q;
    assign done      = done_q;
    assign err       = err_q;

    // Client state machine with all bus/handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            base_q      <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            bus_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ARB_CLIENT_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_q       <= 1'b0;
                    bus_valid_q <= 1'b0;
                    bus_last_q  <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        len_q   <= cmd_len;
                        base_q  <= cmd_data;
                        count_q <= '0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`ifdef ARB_CLIENT_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (gnt) begin
                        bus_valid_q <= 1'b1;
                        bus_data_q  <= base_q;
                        bus_last_q  <= (len_q == '0);
                        count_q     <= (LEN_W+1)'(1);
                        if (len_q == '0) begin
                            done_q  <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_XFER;
                        end
                    end
`ifdef ARB_CLIENT_TIMEOUT_EN
                    else if (wait_q == WAIT_LIMIT) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        wait_q  <= wait_q + 1'b1;
                    end
`endif
                end
                S_XFER: begin
                    if (gnt) begin
                        bus_valid_q <= 1'b1;
                        bus_data_q  <= beat_data_d;
                        bus_last_q  <= last_beat_d;
                        count_q     <= count_q + 1'b1;
                        if (last_beat_d) begin
                            done_q  <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        // Grant withdrawn mid-burst: abandon the remaining beats.
                        err_q       <= 1'b1;
                        req_q       <= 1'b0;
                        bus_valid_q <= 1'b0;
                        bus_last_q  <= 1'b0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    req_q       <= 1'b0;
                    bus_valid_q <= 1'b0;
                    bus_last_q  <= 1'b0;
                    if (!gnt) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_client.sv
// tb/tb_arb_client.sv - scoreboard bench for arb_client with a 2-cycle registered arbiter model
module tb_arb_client;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              done;
    logic              err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    pending_err = 0;

    logic [1:0] gnt_pipe = 2'b00;
    logic       gnt_kill = 1'b0;

    always #5 clk = ~clk;

    arb_client #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .req       (req),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_last  (bus_last),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    // Arbiter model: grant follows req two cycles later; gnt_kill forces it low.
    assign gnt = gnt_pipe[1] & ~gnt_kill;
    always begin
        @(posedge clk);
        #2;
        gnt_pipe = {gnt_pipe[0], req};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pop and compare whenever the DUT presents a beat or a status pulse.
    always @(negedge clk) begin
        beat_t b;
        if (bus_valid) begin
            if (exp_q.size() == 0) begin
                fail_now($sformatf("unexpected_beat data=%h", bus_data));
            end else begin
                b = exp_q.pop_front();
                check("beat_data", bus_data, b.data);
                check("beat_last", {31'd0, bus_last}, {31'd0, b.last});
                check("done_with_last", {31'd0, done}, {31'd0, b.last});
            end
        end else if (done) begin
            fail_now("done_without_beat");
        end
        if (err) begin
            if (pending_err > 0) begin
                checks++;
                pending_err--;
            end else begin
                fail_now("unexpected_err");
            end
        end
        if (done) check("req_low_on_done", {31'd0, req}, 32'd0);
        if (done && err) fail_now("done_and_err_together");
    end

    task automatic push_burst(input int len, input logic [DATA_W-1:0] base);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            b.data = base + DATA_W'(k);
            b.last = (k == len);
            exp_q.push_back(b);
        end
    endtask

    // Offer a command at a negedge and return at the negedge after it is taken.
    task automatic issue(input int len, input logic [DATA_W-1:0] base);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_data  = base;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("cmd_ready_timeout");
        @(negedge clk);
        cmd_valid = 1'b0;
        check("req_after_accept", {31'd0, req}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now({name, "_idle_timeout"});
    endtask

    task automatic wait_beat(input logic [DATA_W-1:0] data, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_valid && bus_data == data) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now({name, "_beat_timeout"});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        int n;
        int viol;
        beat_t b;
        bit ok;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_bus_data", bus_data, 32'd0);
        check("rst_bus_last", {31'd0, bus_last}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Basic 4-beat burst from 0x10.
        push_burst(3, 32'h10);
        issue(3, 32'h10);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("basic_first_beat_timeout");
        n = 0;
        while (bus_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("basic_consecutive_beats", n, 32'd4);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!gnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("basic_gnt_fall_timeout");
        check("basic_ready_while_gnt_falls", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("basic_ready_after_gnt_fall", {31'd0, cmd_ready}, 32'd1);
        wait_idle("basic");

        // Single beat at the top of the range, then a two-beat wrap.
        push_burst(0, 32'hFFFF_FFFF);
        issue(0, 32'hFFFF_FFFF);
        wait_idle("single");
        b.data = 32'hFFFF_FFFF; b.last = 1'b0; exp_q.push_back(b);
        b.data = 32'h0000_0000; b.last = 1'b1; exp_q.push_back(b);
        issue(1, 32'hFFFF_FFFF);
        wait_idle("wrap");

        // Grant loss after beat 2 of an 8-beat burst.
        for (int k = 0; k < 3; k++) begin
            b.data = 32'h300 + 32'(k);
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        pending_err++;
        issue(7, 32'h300);
        wait_beat(32'h302, "loss");
        gnt_kill = 1'b1;
        @(negedge clk);
        check("loss_err_pulse", {31'd0, err}, 32'd1);
        check("loss_req_low", {31'd0, req}, 32'd0);
        check("loss_no_done", {31'd0, done}, 32'd0);
        wait_idle("loss");
        repeat (4) @(negedge clk);
        gnt_kill = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back: second command held off until the grant drops.
        push_burst(1, 32'h400);
        push_burst(2, 32'h500);
        issue(1, 32'h400);
        cmd_valid = 1'b1;
        cmd_len   = 4'd2;
        cmd_data  = 32'h500;
        viol = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            if (gnt && busy) viol = viol;
            @(negedge clk);
            if (cmd_ready && (gnt || busy)) viol++;
        end
        if (!ok) fail_now("b2b_ready_timeout");
        check("b2b_holdoff_violations", viol, 32'd0);
        check("b2b_gnt_low_when_ready", {31'd0, gnt}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_req_rearmed", {31'd0, req}, 32'd1);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle("b2b");
        repeat (4) @(negedge clk);

        // Reset after beat 1 of a 4-beat burst.
        b.data = 32'h600; b.last = 1'b0; exp_q.push_back(b);
        b.data = 32'h601; b.last = 1'b0; exp_q.push_back(b);
        issue(3, 32'h600);
        wait_beat(32'h601, "rstmid");
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_req", {31'd0, req}, 32'd0);
        check("rstmid_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_err", {31'd0, err}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_stale_gnt", {31'd0, gnt}, 32'd1);
        check("rstmid_ready_blocked", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_ready_after_gnt", {31'd0, cmd_ready}, 32'd1);

        // Grant never arrives.
        gnt_kill = 1'b1;
`ifdef ARB_CLIENT_TIMEOUT_EN
        pending_err++;
`endif
        issue(2, 32'h700);
        n = 1;
`ifdef ARB_CLIENT_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!req) break;
            n++;
        end
        check("timeout_req_cycles", n, TIMEOUT);
        check("timeout_err_pulse", {31'd0, err}, 32'd1);
        wait_idle("timeout");
`else
        for (int i = 1; i < 120; i++) begin
            @(negedge clk);
            if (req) n++;
        end
        check("no_timeout_req_held", n, 32'd120);
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (4) @(negedge clk);
        gnt_kill = 1'b0;
        repeat (4) @(negedge clk);

        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("pending_err_empty", pending_err, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
